// File: rtl/apb_slave_regfile.sv
// APB slave register file: NUM_REGS-1 read/write words plus a read-only STATUS word
// holding {ID_CODE, error count}, with a programmable number of access-phase wait states.
module apb_slave_regfile #(
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] ID_CODE     = 16'hA5B0
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    input  logic [3:0]  PSTRB,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);

    // state  | meaning
    // IDLE   | waiting for a setup phase (PSEL=1, PENABLE=0)
    // ACCESS | request captured; counting wait states until PREADY
    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt;
    logic [7:0]  cap_addr;
    logic        cap_write;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_strb;
    logic [31:0] regs [NUM_REGS-1];
    logic [15:0] errcnt;

    logic [5:0]  idx;
    logic        setup;
    logic        active;
    logic        xfer_err;
    logic [31:0] rd_mux;

    assign setup  = PSEL && !PENABLE;
    assign active = (state == ACCESS) && PSEL && PENABLE;
    assign idx    = cap_addr[7:2];

    // Error decode works on the captured request so mid-access bus changes are ignored.
    assign xfer_err = (cap_addr[1:0] != 2'b00)
                   || ({1'b0, idx} >= 7'(NUM_REGS))
                   || (cap_write && ({1'b0, idx} == 7'(NUM_REGS - 1)));

    assign PREADY  = active && (wait_cnt == 4'd0);
    assign PSLVERR = PREADY && xfer_err;
    assign PRDATA  = (PREADY && !xfer_err && !cap_write) ? rd_mux : 32'h0;

    always_comb begin
        rd_mux = {ID_CODE, errcnt};
        for (int i = 0; i < NUM_REGS - 1; i++) begin
            if (idx == 6'(i)) begin
                rd_mux = regs[i];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (setup) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (!active || PREADY) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt  <= 4'd0;
            cap_addr  <= 8'h0;
            cap_write <= 1'b0;
            cap_wdata <= 32'h0;
            cap_strb  <= 4'h0;
        end else if (state == IDLE) begin
            if (setup) begin
                wait_cnt  <= 4'(WAIT_CYCLES);
                cap_addr  <= PADDR;
                cap_write <= PWRITE;
                cap_wdata <= PWDATA;
                cap_strb  <= PSTRB;
            end
        end else if (!active) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Register and error-count updates happen only on a completion edge.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                regs[i] <= 32'h0;
            end
            errcnt <= 16'h0;
        end else if (PREADY) begin
            if (xfer_err) begin
                if (errcnt != 16'hFFFF) begin
                    errcnt <= errcnt + 16'd1;
                end
            end else if (cap_write) begin
                for (int i = 0; i < NUM_REGS - 1; i++) begin
                    if (idx == 6'(i)) begin
                        for (int b = 0; b < 4; b++) begin
                            if (cap_strb[b]) begin
                                regs[i][8*b +: 8] <= cap_wdata[8*b +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench for apb_slave_regfile: directed scenarios plus randomized
// back-to-back traffic checked against a behavioural register-map model.
module tb_apb_slave_regfile;

    localparam int NR = 8;
    localparam int WC = 2;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [7:0]  PADDR = 8'h0;
    logic [31:0] PWDATA = 32'h0;
    logic [3:0]  PSTRB = 4'h0;
    logic [31:0] PRDATA, z_PRDATA;
    logic        PREADY, z_PREADY;
    logic        PSLVERR, z_PSLVERR;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_regs [0:NR-2];
    int          m_errcnt;

    always #5 PCLK = ~PCLK;

    apb_slave_regfile #(.NUM_REGS(NR), .WAIT_CYCLES(WC), .ID_CODE(16'hA5B0)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    // Zero-wait instance on the same bus: must finish every transfer in access cycle 1.
    apb_slave_regfile #(.NUM_REGS(NR), .WAIT_CYCLES(0), .ID_CODE(16'hA5B0)) dut_z (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(z_PRDATA), .PREADY(z_PREADY), .PSLVERR(z_PSLVERR)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        for (int i = 0; i < NR - 1; i++) m_regs[i] = 32'h0;
        m_errcnt = 0;
    endtask

    // Register-map rules applied to one completed transfer.
    task automatic model_xfer(input logic [7:0] addr, input logic wr, input logic [31:0] wd,
                              input logic [3:0] st, output logic [31:0] exp_rd, output logic exp_er);
        int ix;
        ix = int'(addr) / 4;
        exp_er = (int'(addr) % 4 != 0) || (ix >= NR) || (wr && ix == NR - 1);
        exp_rd = 32'h0;
        if (exp_er) begin
            if (m_errcnt < 65535) m_errcnt = m_errcnt + 1;
        end else if (wr) begin
            for (int b = 0; b < 4; b++)
                if (st[b]) m_regs[ix][8*b +: 8] = wd[8*b +: 8];
        end else if (ix == NR - 1) begin
            exp_rd = {16'hA5B0, 16'(m_errcnt)};
        end else begin
            exp_rd = m_regs[ix];
        end
    endtask

    // Drives one transfer starting just after a clock edge; drop_at=k drops PSEL in access cycle k.
    task automatic apb_xfer(input logic [7:0] addr, input logic wr, input logic [31:0] wd,
                            input logic [3:0] st, input bit scramble, input int drop_at,
                            output logic [31:0] rd, output logic er, output int lat,
                            output logic z_rdy, output logic z_er, output logic [31:0] z_rd,
                            output bit idle_bad);
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wd; PSTRB = st;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        if (scramble) begin
            PADDR = 8'($urandom); PWRITE = 1'($urandom); PWDATA = $urandom; PSTRB = 4'($urandom);
        end
        lat = 0; rd = 32'h0; er = 1'b0; z_rdy = 1'b0; z_er = 1'b0; z_rd = 32'h0; idle_bad = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            if (c == drop_at) PSEL = 1'b0;
            @(negedge PCLK);
            if (c == 1) begin z_rdy = z_PREADY; z_er = z_PSLVERR; z_rd = z_PRDATA; end
            if (PREADY === 1'b1) begin
                lat = c; rd = PRDATA; er = PSLVERR;
                break;
            end
            if (PRDATA !== 32'h0 || PSLVERR !== 1'b0) idle_bad = 1'b1;
            @(posedge PCLK); #1;
            if (drop_at != 0 && c >= drop_at) break;
        end
        if (lat != 0) begin
            @(posedge PCLK); #1;
        end
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    logic [31:0] rd, exp_rd, z_rd;
    logic        er, exp_er, z_rdy, z_er;
    int          lat;
    bit          ib;

    task automatic test_reset();
        PRESETn = 1'b0;
        #23;
        n_tests++;
        if ({PREADY, PSLVERR, PRDATA} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b err=%b rdata=%h, want 0/0/0", PREADY, PSLVERR, PRDATA);
        end
        model_reset();
        @(negedge PCLK); PRESETn = 1'b1;
        @(posedge PCLK); #1;
    endtask

    task automatic test_status();
        apb_xfer(8'h1C, 1'b0, 32'h0, 4'h0, 1'b0, 0, rd, er, lat, z_rdy, z_er, z_rd, ib);
        model_xfer(8'h1C, 1'b0, 32'h0, 4'h0, exp_rd, exp_er);
        n_tests++;
        if (rd !== 32'hA5B00000 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL status_reset_read: got %h err=%b, want a5b00000 err=0", rd, er);
        end
        apb_xfer(8'h1C, 1'b1, 32'hFFFFFFFF, 4'hF, 1'b0, 0, rd, er, lat, z_rdy, z_er, z_rd, ib);
        model_xfer(8'h1C, 1'b1, 32'hFFFFFFFF, 4'hF, exp_rd, exp_er);
        n_tests++;
        if (er !== 1'b1 || lat != WC + 1) begin
            n_fail++;
            $display("FAIL status_write_err: got err=%b lat=%0d, want err=1 lat=%0d", er, lat, WC + 1);
        end
        apb_xfer(8'h1C, 1'b0, 32'h0, 4'h0, 1'b0, 0, rd, er, lat, z_rdy, z_er, z_rd, ib);
        model_xfer(8'h1C, 1'b0, 32'h0, 4'h0, exp_rd, exp_er);
        n_tests++;
        if (rd !== 32'hA5B00001) begin
            n_fail++;
            $display("FAIL status_errcnt: got %h, want a5b00001", rd);
        end
    endtask

    task automatic test_write_read();
        apb_xfer(8'h04, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0, 0, rd, er, lat, z_rdy, z_er, z_rd, ib);
        model_xfer(8'h04, 1'b1, 32'hDEADBEEF, 4'hF, exp_rd, exp_er);
        n_tests++;
        if (lat != WC + 1 || er !== 1'b0 || ib) begin
            n_fail++;
            $display("FAIL wr_latency: got lat=%0d err=%b early=%b, want lat=%0d err=0 early=0", lat, er, ib, WC + 1);
        end
        apb_xfer(8'h04, 1'b0, 32'h0, 4'h0, 1'b0, 0, rd, er, lat, z_rdy, z_er, z_rd, ib);
        model_xfer(8'h04, 1'b0, 32'h0, 4'h0, exp_rd, exp_er);
        n_tests++;
        if (lat != WC + 1 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_deadbeef: got lat=%0d rdata=%h err=%b, want lat=%0d deadbeef err=0", lat, rd, er, WC + 1);
        end
    endtask

    task automatic test_strobe();
        apb_xfer(8'h08, 1'b1, 32'h11223344, 4'b0101, 1'b0, 0, rd, er, lat, z_rdy, z_er, z_rd, ib);
        model_xfer(8'h08, 1'b1, 32'h11223344, 4'b0101, exp_rd, exp_er);
        apb_xfer(8'h08, 1'b0, 32'h0, 4'h0, 1'b0, 0, rd, er, lat, z_rdy, z_er, z_rd, ib);
        model_xfer(8'h08, 1'b0, 32'h0, 4'h0, exp_rd, exp_er);
        n_tests++;
        if (rd !== 32'h00220044) begin
            n_fail++;
            $display("FAIL strobe_lanes: got %h, want 00220044", rd);
        end
    endtask

    task automatic test_errors();
        int ec0;
        ec0 = m_errcnt;
        apb_xfer(8'h05, 1'b1, 32'hCAFEF00D, 4'hF, 1'b0, 0, rd, er, lat, z_rdy, z_er, z_rd, ib);
        model_xfer(8'h05, 1'b1, 32'hCAFEF00D, 4'hF, exp_rd, exp_er);
        n_tests++;
        if (er !== 1'b1 || lat != WC + 1) begin
            n_fail++;
            $display("FAIL unaligned_err: got err=%b lat=%0d, want err=1 lat=%0d", er, lat, WC + 1);
        end
        apb_xfer(8'h20, 1'b0, 32'h0, 4'h0, 1'b0, 0, rd, er, lat, z_rdy, z_er, z_rd, ib);
        model_xfer(8'h20, 1'b0, 32'h0, 4'h0, exp_rd, exp_er);
        n_tests++;
        if (er !== 1'b1 || lat != WC + 1 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL range_err: got err=%b lat=%0d rdata=%h, want err=1 lat=%0d rdata=0", er, lat, rd, WC + 1);
        end
        for (int i = 0; i < NR - 1; i++) begin
            apb_xfer(8'(4 * i), 1'b0, 32'h0, 4'h0, 1'b0, 0, rd, er, lat, z_rdy, z_er, z_rd, ib);
            model_xfer(8'(4 * i), 1'b0, 32'h0, 4'h0, exp_rd, exp_er);
            n_tests++;
            if (rd !== exp_rd) begin
                n_fail++;
                $display("FAIL err_no_change reg%0d: got %h, want %h", i, rd, exp_rd);
            end
        end
        apb_xfer(8'h1C, 1'b0, 32'h0, 4'h0, 1'b0, 0, rd, er, lat, z_rdy, z_er, z_rd, ib);
        model_xfer(8'h1C, 1'b0, 32'h0, 4'h0, exp_rd, exp_er);
        n_tests++;
        if (rd !== {16'hA5B0, 16'(ec0 + 2)}) begin
            n_fail++;
            $display("FAIL errcnt_plus2: got %h, want %h", rd, {16'hA5B0, 16'(ec0 + 2)});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  a;
        logic        w;
        logic [31:0] d;
        logic [3:0]  s;
        int          r;
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 15);
            if (r < 12)       a = 8'(4 * $urandom_range(0, NR - 2));
            else if (r == 12) a = 8'(4 * (NR - 1));
            else if (r == 13) a = 8'({$urandom_range(0, NR - 1), 2'b00} | $urandom_range(1, 3));
            else if (r == 14) a = 8'(4 * $urandom_range(NR, 63));
            else              a = 8'($urandom);
            w = 1'($urandom);
            d = $urandom;
            s = 4'($urandom);
            apb_xfer(a, w, d, s, 1'b1, 0, rd, er, lat, z_rdy, z_er, z_rd, ib);
            model_xfer(a, w, d, s, exp_rd, exp_er);
            n_tests++;
            if (lat != WC + 1 || ib) begin
                n_fail++;
                $display("FAIL b2b_latency #%0d: got lat=%0d early=%b, want lat=%0d early=0", n, lat, ib, WC + 1);
            end
            n_tests++;
            if (rd !== exp_rd || er !== exp_er) begin
                n_fail++;
                $display("FAIL b2b_data #%0d addr=%h wr=%b: got %h err=%b, want %h err=%b", n, a, w, rd, er, exp_rd, exp_er);
            end
            n_tests++;
            if (z_rdy !== 1'b1 || z_er !== exp_er || z_rd !== exp_rd) begin
                n_fail++;
                $display("FAIL zero_wait #%0d: got ready=%b err=%b rdata=%h, want 1 %b %h", n, z_rdy, z_er, z_rd, exp_er, exp_rd);
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge PCLK); #1;
            end
        end
    endtask

    task automatic test_abort();
        bit saw_ready;
        int ec0;
        ec0 = m_errcnt;
        apb_xfer(8'h00, 1'b1, 32'h12345678, 4'hF, 1'b0, 2, rd, er, lat, z_rdy, z_er, z_rd, ib);
        n_tests++;
        if (lat != 0) begin
            n_fail++;
            $display("FAIL abort_no_ready: got ready in cycle %0d, want none", lat);
        end
        // Access-phase signalling without a setup phase must be ignored once back in IDLE.
        PSEL = 1'b1; PENABLE = 1'b1; PADDR = 8'h00; PWRITE = 1'b1;
        saw_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge PCLK);
            if (PREADY !== 1'b0) saw_ready = 1'b1;
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        n_tests++;
        if (saw_ready) begin
            n_fail++;
            $display("FAIL abort_idle: got PREADY=1 without setup, want 0");
        end
        apb_xfer(8'h00, 1'b0, 32'h0, 4'h0, 1'b0, 0, rd, er, lat, z_rdy, z_er, z_rd, ib);
        model_xfer(8'h00, 1'b0, 32'h0, 4'h0, exp_rd, exp_er);
        n_tests++;
        if (rd !== exp_rd) begin
            n_fail++;
            $display("FAIL abort_reg0: got %h, want %h", rd, exp_rd);
        end
        apb_xfer(8'h1C, 1'b0, 32'h0, 4'h0, 1'b0, 0, rd, er, lat, z_rdy, z_er, z_rd, ib);
        model_xfer(8'h1C, 1'b0, 32'h0, 4'h0, exp_rd, exp_er);
        n_tests++;
        if (rd[15:0] !== 16'(ec0)) begin
            n_fail++;
            $display("FAIL abort_errcnt: got %h, want %h", rd[15:0], 16'(ec0));
        end
    endtask

    task automatic test_reset_mid();
        bit ready_seen;
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 8'h00; PWRITE = 1'b1; PWDATA = 32'hA5A5A5A5; PSTRB = 4'hF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        repeat (WC) begin
            @(posedge PCLK); #1;
        end
        @(negedge PCLK);
        ready_seen = PREADY;
        #1 PRESETn = 1'b0;
        #1;
        n_tests++;
        if (ready_seen !== 1'b1 || {PREADY, PSLVERR, PRDATA} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got pre=%b ready=%b err=%b rdata=%h, want pre=1 then 0/0/0", ready_seen, PREADY, PSLVERR, PRDATA);
        end
        model_reset();
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK); PRESETn = 1'b1;
        @(posedge PCLK); #1;
        apb_xfer(8'h00, 1'b0, 32'h0, 4'h0, 1'b0, 0, rd, er, lat, z_rdy, z_er, z_rd, ib);
        model_xfer(8'h00, 1'b0, 32'h0, 4'h0, exp_rd, exp_er);
        n_tests++;
        if (rd !== 32'h0 || lat != WC + 1) begin
            n_fail++;
            $display("FAIL post_reset_read: got %h lat=%0d, want 00000000 lat=%0d", rd, lat, WC + 1);
        end
        apb_xfer(8'h1C, 1'b0, 32'h0, 4'h0, 1'b0, 0, rd, er, lat, z_rdy, z_er, z_rd, ib);
        model_xfer(8'h1C, 1'b0, 32'h0, 4'h0, exp_rd, exp_er);
        n_tests++;
        if (rd !== 32'hA5B00000) begin
            n_fail++;
            $display("FAIL post_reset_status: got %h, want a5b00000", rd);
        end
    endtask

    initial begin
        test_reset();
        test_status();
        test_write_read();
        test_strobe();
        test_errors();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
